mem_bridge: RTL and testbench

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge.sv | 167 ++++++++++++++++
 tb/tb_mem_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// Processor-to-memory bridge with a posted write buffer and a stalling read path.
// Optional read forwarding from the write buffer is enabled by defining MEM_BRIDGE_FWD_EN.
module mem_bridge #(
   parameter int DEPTH = 4
) (
   input  logic        Clk1,
   input  logic        Reset,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] DataOut,
   output logic [15:0] DataIn,
   output logic        Wait,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [3:0]  wb_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {IDLE, WDRAIN, RDRAIN, RREQ, RDONE} state_e;

   state_e          state_q, state_d;
   logic [15:0]     addr_mem [DEPTH];
   logic [15:0]     data_mem [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [15:0]     din_q, din_d;
   logic            mreq_q, mreq_d, mwe_q, mwe_d;
   logic [15:0]     maddr_q, maddr_d, mwdata_q, mwdata_d;

   logic            full, read_busy, push, pop, acked;
   logic            rd_new, fwd_hit, fwd_acc;
   logic [15:0]     fwd_data;

`ifdef MEM_BRIDGE_FWD_EN
   // Later offsets from the head are younger entries, so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((4'(i) < cnt_q) && (addr_mem[rd_ptr_q + PW'(i)] == Addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_mem[rd_ptr_q + PW'(i)];
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      read_busy = (state_q == RDRAIN) || (state_q == RREQ);
      full      = (cnt_q == 4'(DEPTH));
      fwd_acc   = RD && !WR && fwd_hit && !read_busy && (state_q != RDONE);
      rd_new    = RD && !WR && !fwd_hit;
      Wait      = 1'b0;
      if (WR)
         Wait = full || read_busy;
      else if (RD && !fwd_acc)
         Wait = (state_q != RDONE);
      push     = WR && !Wait;
      acked    = mreq_q && mem_ack;
      pop      = acked && mwe_q;
      cnt_d    = cnt_q + {3'b000, push} - {3'b000, pop};
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
   end

   always_comb begin
      state_d  = state_q;
      mreq_d   = mreq_q;
      mwe_d    = mwe_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      din_d    = fwd_acc ? fwd_data : din_q;

      // Requests launch only from a deasserted mem_req, which guarantees the idle gap after each ack.
      if (!mreq_q && ((state_q == WDRAIN) || (state_q == RDRAIN))) begin
         mreq_d   = 1'b1;
         mwe_d    = 1'b1;
         maddr_d  = addr_mem[rd_ptr_q];
         mwdata_d = data_mem[rd_ptr_q];
      end else if (!mreq_q && (state_q == RREQ)) begin
         mreq_d  = 1'b1;
         mwe_d   = 1'b0;
         maddr_d = Addr;
      end else if (acked) begin
         mreq_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (rd_new)
               state_d = (cnt_q != 4'd0) ? RDRAIN : RREQ;
            else if (cnt_q != 4'd0)
               state_d = WDRAIN;
         end
         WDRAIN: begin
            if (acked) begin
               if (rd_new)
                  state_d = (cnt_d != 4'd0) ? RDRAIN : RREQ;
               else
                  state_d = (cnt_d != 4'd0) ? WDRAIN : IDLE;
            end
         end
         RDRAIN: begin
            if (acked && (cnt_d == 4'd0))
               state_d = RREQ;
         end
         RREQ: begin
            if (acked) begin
               din_d   = mem_rdata;
               state_d = RDONE;
            end
         end
         RDONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk1) begin
      if (!Reset) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         din_q    <= '0;
         mreq_q   <= 1'b0;
         mwe_q    <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         din_q    <= din_d;
         mreq_q   <= mreq_d;
         mwe_q    <= mwe_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   // NOTE: buffer storage carries no reset; emptiness is defined by the pointers and count alone.
   always_ff @(posedge Clk1) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= Addr;
         data_mem[wr_ptr_q] <= DataOut;
      end
   end

   assign DataIn    = din_q;
   assign mem_req   = mreq_q;
   assign mem_we    = mwe_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;
   assign wb_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: transaction-level reference model plus directed scenarios.
// Define MEM_BRIDGE_FWD_EN for both files to exercise the forwarding build.
module tb_mem_bridge;

   localparam int DEPTH = 4;

   logic        Clk1 = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] Addr = '0;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] DataOut = '0;
   logic [15:0] DataIn;
   logic        Wait;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [3:0]  wb_cnt;

   mem_bridge #(.DEPTH(DEPTH)) dut (
      .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut),
      .DataIn(DataIn), .Wait(Wait), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .wb_cnt(wb_cnt)
   );

   always #5 Clk1 = ~Clk1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- memory responder (acts 2 time units after each edge) ----------------
   int          lat = 2;
   int          lat_cnt = 0;
   int          hold_cyc = 0;
   bit          hold = 1'b0;
   bit          stray = 1'b0;
   bit          fixed_en = 1'b0;
   logic [15:0] fixed_val = '0;
   int          n_mem_reads = 0;
   logic [15:0] wr_log[$];

   always @(posedge Clk1) begin
      #2;
      mem_ack = 1'b0;
      if (hold_cyc > 0) hold_cyc--;
      if (stray) begin
         mem_ack = 1'b1;
      end else if (mem_req && !hold && hold_cyc == 0) begin
         lat_cnt++;
         if (lat_cnt >= lat) begin
            mem_ack   = 1'b1;
            lat_cnt   = 0;
            mem_rdata = fixed_en ? fixed_val : 16'($urandom);
            if (mem_we) wr_log.push_back(mem_addr);
            else        n_mem_reads++;
         end
      end else if (!mem_req) begin
         lat_cnt = 0;
      end
   end

   // ---------------- reference model and per-cycle compare ----------------
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } ent_t;

   ent_t        mq[$];
   bit          rd_pend = 1'b0, rd_done = 1'b0, seen_rst = 1'b0, prev_rst = 1'b0;
   logic [15:0] rd_addr = '0, exp_din = '0;
   bit          prev_req = 1'b0, prev_ack = 1'b0;
   logic        prev_we = 1'b0;
   logic [15:0] prev_addr = '0, prev_wdata = '0;

   always @(negedge Clk1) begin
      bit          hit, exp_wait, acc;
      logic [15:0] hit_d;
      hit   = 1'b0;
      hit_d = '0;
      foreach (mq[i]) begin
         if (mq[i].a == Addr) begin
            hit   = 1'b1;
            hit_d = mq[i].d;
         end
      end
`ifndef MEM_BRIDGE_FWD_EN
      hit = 1'b0;
`endif
      if (seen_rst) begin
         check("wb_cnt", wb_cnt, mq.size());
         check("DataIn", DataIn, exp_din);
         if (prev_rst)
            check("reset_mem_outputs", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
         else if (prev_req && prev_ack)
            check("mem_req_gap", mem_req, 1'b0);
         else if (prev_req && mem_req)
            check("mem_stable", {mem_we, mem_addr, mem_wdata}, {prev_we, prev_addr, prev_wdata});
         if (Reset && (RD || WR)) begin
            if (WR)           exp_wait = (mq.size() == DEPTH) || (rd_pend && !rd_done);
            else if (rd_done) exp_wait = 1'b0;
            else              exp_wait = !(hit && !rd_pend);
            check("Wait", Wait, exp_wait);
         end
         if (Reset && mem_req && mem_ack) begin
            if (mem_we) begin
               check("wr_pending", mq.size() != 0, 1'b1);
               check("wr_order", {mem_addr, mem_wdata}, (mq.size() != 0) ? mq[0] : ent_t'(0));
            end else begin
               check("rd_after_drain", mq.size(), 0);
               check("rd_addr", mem_addr, rd_addr);
            end
         end
      end

      if (!Reset) begin
         mq.delete();
         rd_pend  = 1'b0;
         rd_done  = 1'b0;
         exp_din  = '0;
         prev_rst = 1'b1;
         seen_rst = 1'b1;
      end else begin
         prev_rst = 1'b0;
         acc = (RD || WR) && !Wait;
         if (rd_done) begin
            rd_done = 1'b0;
            rd_pend = 1'b0;
         end else if (RD && !WR) begin
            if (acc && hit) exp_din = hit_d;
            else if (!acc && !rd_pend) begin
               rd_pend = 1'b1;
               rd_addr = Addr;
            end
         end
         if (mem_req && mem_ack) begin
            if (mem_we) begin
               if (mq.size() != 0) void'(mq.pop_front());
            end else begin
               exp_din = mem_rdata;
               rd_done = 1'b1;
            end
         end
         if (WR && acc) mq.push_back({Addr, DataOut});
      end
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
   end

   // ---------------- processor-side stimulus helpers (drive 1 unit after each edge) ----------------
   task automatic wait_accept(input string name);
      int k = 0;
      forever begin
         @(negedge Clk1);
         if (!Wait) break;
         k++;
         if (k > 300) begin
            timeout_fail(name);
            break;
         end
      end
      @(posedge Clk1); #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      WR = 1'b1; Addr = a; DataOut = d;
      wait_accept("write_accept");
      WR = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] a);
      RD = 1'b1; Addr = a;
      wait_accept("read_accept");
      RD = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge Clk1);
      #1;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      for (int k = 0; k < 600; k++) begin
         @(posedge Clk1); #1;
         quiet = (wb_cnt == 0 && !mem_req) ? quiet + 1 : 0;
         if (quiet >= 3) return;
      end
      timeout_fail("drain_idle");
   endtask

   task automatic wait_mem_req(input string name);
      for (int k = 0; k < 100; k++) begin
         if (mem_req) return;
         @(posedge Clk1); #1;
      end
      timeout_fail(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int l0;
      Reset = 1'b0;
      repeat (2) @(posedge Clk1);
      #1;
      Reset = 1'b1;
      check("rst_state", {wb_cnt, DataIn, mem_req}, '0);

      // Single posted write, ack latency 2
      lat = 2;
      wr_log.delete();
      do_write(16'h0010, 16'hBEEF);
      check("t1_wb_cnt_after_accept", wb_cnt, 4'd1);
      wait_mem_req("t1_mem_req");
      check("t1_mem_txn", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0010, 16'hBEEF});
      wait_idle();
      check("t1_wb_cnt_after_ack", wb_cnt, 4'd0);
      check("t1_log", wr_log.size() == 1 ? wr_log[0] : 16'hFFFF, 16'h0010);

      // Five back-to-back writes against a stalled memory
      hold = 1'b1;
      wr_log.delete();
      for (int i = 1; i <= 4; i++) do_write(16'(i), 16'(i * 16'h0101));
      check("t2_full_cnt", wb_cnt, 4'd4);
      WR = 1'b1; Addr = 16'd5; DataOut = 16'h0505;
      @(negedge Clk1);
      check("t2_fifth_waits", Wait, 1'b1);
      @(posedge Clk1); #1;
      hold = 1'b0;
      wait_accept("t2_fifth_accept");
      WR = 1'b0;
      wait_idle();
      check("t2_log_len", wr_log.size(), 5);
      for (int i = 0; i < 5; i++)
         check("t2_mem_order", (i < wr_log.size()) ? wr_log[i] : 16'hFFFF, 16'(i + 1));

      // Read-after-write to the same address
      fixed_en  = 1'b1;
      fixed_val = 16'hCAFE;
      r0 = n_mem_reads;
      hold = 1'b1;
      wr_log.delete();
      do_write(16'h0020, 16'h1111);
      do_write(16'h0020, 16'h2222);
`ifdef MEM_BRIDGE_FWD_EN
      do_read(16'h0020);
      check("t3_fwd_data", DataIn, 16'h2222);
      check("t3_no_mem_read", n_mem_reads - r0, 0);
      hold = 1'b0;
      wait_idle();
`else
      hold = 1'b0;
      do_read(16'h0020);
      check("t3_mem_data", DataIn, 16'hCAFE);
      check("t3_one_mem_read", n_mem_reads - r0, 1);
      check("t3_writes_first", wr_log.size(), 2);
`endif

      // Read from an empty buffer, ack latency 3
      lat       = 3;
      fixed_val = 16'h5A5A;
      r0 = n_mem_reads;
      do_read(16'h0030);
      check("t4_data", DataIn, 16'h5A5A);
      check("t4_one_read", n_mem_reads - r0, 1);
      fixed_en = 1'b0;

      // Reset in the middle of a read that is waiting on buffered writes
      hold = 1'b1;
      do_write(16'h0050, 16'h0001);
      do_write(16'h0051, 16'h0002);
      RD = 1'b1; Addr = 16'h0040;
      wait_mem_req("t5_mem_req");
      check("t5_cnt_before", wb_cnt, 4'd2);
      Reset = 1'b0; RD = 1'b0;
      @(posedge Clk1); #1;
      check("t5_after_reset", {mem_req, wb_cnt, DataIn}, '0);
      Reset = 1'b1;
      hold  = 1'b0;
      stray = 1'b1;
      @(posedge Clk1); #1;
      stray = 1'b0;
      wait_cycles(2);
      check("t5_stray_ack", {mem_req, wb_cnt, DataIn}, '0);

      // Randomized traffic over a small address window
      l0 = wr_log.size();
      for (int n = 0; n < 400; n++) begin
         int          op;
         logic [15:0] a;
         lat = $urandom_range(1, 4);
         if ($urandom_range(0, 7) == 0) hold_cyc = $urandom_range(2, 12);
         op = $urandom_range(0, 2);
         a  = 16'h0060 + 16'($urandom_range(0, 3));
         if (op < 2) do_write(a, 16'($urandom));
         else        do_read(a);
         if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
      end
      wait_idle();
      check("rand_drained", wb_cnt, 4'd0);
      check("rand_some_writes", wr_log.size() > l0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
